pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Avalon-MM read master that polls the PLL reset monitor's 32-bit CSR at address 0.
- Decodes the monitor's lock_success / lock_failure status bits from that CSR.
- On lock failure, pulses a PLL reset request and retries up to a bounded count.
- Sits in the same clock domain as the monitor's s0 slave. Drives the monitor's pll_reset_request input and reports lock state to system logic.

Parameters:
- POLL_INTERVAL, 64: idle cycles between consecutive CSR reads (>=1).
- RESET_CYCLES, 4: width of the pll_reset_request pulse, in cycles (>=1).
- MAX_RETRIES, 3: reset requests issued before declaring permanent failure (1..15).
- READ_TIMEOUT, 16: cycles allowed from read acceptance to readdatavalid.
- SUCCESS_BIT, 24: CSR bit index meaning lock success.
- FAILURE_BIT, 26: CSR bit index meaning lock failure.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; supervisor leaves IDLE only while high.
- avm_address  out  4  always 0.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  CSR data.
- avm_readdatavalid  in  1  read response strobe.
- pll_reset_request  out  1  reset pulse to the monitor/PLL.
- locked  out  1  last decoded status was success.
- failed  out  1  sticky permanent failure.
- retry_count  out  4  reset requests issued since leaving IDLE.
- last_status  out  32  most recent valid readdata.
- read_timeout_err  out  1  sticky; a read got no response within READ_TIMEOUT.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0.
- IDLE: wait until enable=1, then go to WAIT_POLL with the poll counter loaded to POLL_INTERVAL-1.
- WAIT_POLL: decrement the counter each cycle. At 0, go to READ. The first read therefore issues POLL_INTERVAL cycles after leaving IDLE.
- READ: avm_read=1, avm_address=0.
  - Hold avm_read and address stable while avm_waitrequest=1.
  - Read is accepted in the first cycle with avm_read=1 and waitrequest=0. Next state is WAIT_DATA and the timeout counter clears.
  - avm_read is deasserted the cycle after acceptance. Only one read is ever outstanding.
- WAIT_DATA: wait for avm_readdatavalid.
  - If readdatavalid arrives in the same cycle as acceptance, capture it then.
  - On readdatavalid: register last_status and go to DECIDE.
  - If READ_TIMEOUT cycles pass with no response: set read_timeout_err, go to WAIT_POLL. locked, failed and retry_count are unchanged.
- DECIDE (one cycle):
  - Success: status[SUCCESS_BIT]=1 and status[FAILURE_BIT]=0. Set locked=1, retry_count=0, go to WAIT_POLL.
  - Failure: status[FAILURE_BIT]=1, takes priority if both bits are set. Set locked=0.
    - If retry_count < MAX_RETRIES: go to RESET_PULSE.
    - Otherwise: set failed=1, go to FAILED.
  - Pending: neither bit set. Set locked=0, go to WAIT_POLL, no reset issued.
- RESET_PULSE: pll_reset_request=1 for exactly RESET_CYCLES cycles.
  - retry_count increments on entry and saturates at 15.
  - Then go to WAIT_POLL.
- FAILED: terminal. pll_reset_request=0, avm_read=0. Left only by reset.
- Dropping enable:
  - Takes effect only in WAIT_POLL or DECIDE: return to IDLE with locked, retry_count and last_status retained.
  - In READ, WAIT_DATA and RESET_PULSE the current transaction or pulse completes first.
- pll_reset_request is registered and glitch-free. It is never asserted while a read is outstanding.
- Reset mid-read: the master drops avm_read immediately. A late readdatavalid in IDLE/WAIT_POLL is ignored.

Test Plan:
- Success path: enable=1; slave returns 0x0340009C after 2 waitrequest cycles. Required: first avm_read 64 cycles after enable; read held 3 cycles; locked=1 one cycle after readdatavalid; retry_count=0; pll_reset_request never asserted.
- Failure with recovery: slave returns 0x04400088, then 0x0340009C. Required: pll_reset_request high exactly 4 cycles; retry_count=1; next read returns success; locked=1; retry_count cleared to 0.
- Permanent failure: slave always returns 0x04400088. Required: 3 reset pulses with retry_count reaching 3; 4th failure read sets failed=1; no further avm_read or pll_reset_request.
- Pending/lost lock: slave returns 0x00400074. Required: locked=0; no reset pulse; polling continues every 64+ cycles; last_status=0x00400074.
- Read timeout: slave accepts the read but never asserts readdatavalid. Required: read_timeout_err=1 sixteen cycles after acceptance; next poll read issued; a subsequent success read sets locked=1.
- Async reset mid-RESET_PULSE and with both CSR bits set (0x05000000): reset drops pll_reset_request within the same cycle and clears all outputs; after release, the both-bits read is treated as failure.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// Avalon-MM read-only bus between the lock supervisor (master) and the
// PLL reset monitor CSR slave.
interface pll_lock_supervisor_if;
  logic [3:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Polls the PLL reset monitor CSR over Avalon-MM, decodes lock status and
// issues a bounded number of PLL reset pulses when lock fails.
module pll_lock_supervisor #(
  parameter int unsigned POLL_INTERVAL = 64,
  parameter int unsigned RESET_CYCLES  = 4,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned READ_TIMEOUT  = 16,
  parameter int unsigned SUCCESS_BIT   = 24,
  parameter int unsigned FAILURE_BIT   = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  pll_lock_supervisor_if.master avm,
  output logic                  pll_reset_request,
  output logic                  locked,
  output logic                  failed,
  output logic [3:0]            retry_count,
  output logic [31:0]           last_status,
  output logic                  read_timeout_err
);
  localparam int unsigned POLL_W  = $clog2(POLL_INTERVAL + 1);
  localparam int unsigned TMO_W   = $clog2(READ_TIMEOUT + 1);
  localparam int unsigned PULSE_W = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_POLL, READ, WAIT_DATA, DECIDE, RESET_PULSE, FAILED
  } state_t;

  state_t state, next_state;

  logic [POLL_W-1:0]  poll_cnt, poll_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic [PULSE_W-1:0] pulse_cnt, pulse_nxt;
  logic               read_q, read_nxt, rreq_nxt;
  logic               locked_nxt, failed_nxt, tmo_err_nxt;
  logic [3:0]         retry_nxt;
  logic [31:0]        status_nxt;

  logic accept_c, rdv_c, poll_done_c, tmo_done_c, pulse_done_c, fail_c, ok_c, can_retry_c;

  assign accept_c     = (state == READ) && !avm.avm_waitrequest;
  assign rdv_c        = avm.avm_readdatavalid;
  assign poll_done_c  = (poll_cnt == '0);
  assign tmo_done_c   = (tmo_cnt == TMO_W'(READ_TIMEOUT - 1));
  assign pulse_done_c = (pulse_cnt == '0);
  // Failure bit wins when the monitor reports both bits.
  assign fail_c       = last_status[FAILURE_BIT];
  assign ok_c         = last_status[SUCCESS_BIT] && !last_status[FAILURE_BIT];
  assign can_retry_c  = (retry_count < 4'(MAX_RETRIES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (enable) next_state = WAIT_POLL;
      WAIT_POLL:   if (!enable) next_state = IDLE;
                   else if (poll_done_c) next_state = READ;
      READ:        if (accept_c) next_state = rdv_c ? DECIDE : WAIT_DATA;
      WAIT_DATA:   if (rdv_c) next_state = DECIDE;
                   else if (tmo_done_c) next_state = WAIT_POLL;
      DECIDE:      if (!enable) next_state = IDLE;
                   else if (fail_c) next_state = can_retry_c ? RESET_PULSE : FAILED;
                   else next_state = WAIT_POLL;
      RESET_PULSE: if (pulse_done_c) next_state = WAIT_POLL;
      FAILED:      next_state = FAILED;
      default:     next_state = IDLE;
    endcase
  end

  // Next values of every registered output and counter.
  always_comb begin
    read_nxt    = (next_state == READ);
    rreq_nxt    = (next_state == RESET_PULSE);
    poll_nxt    = poll_cnt;
    tmo_nxt     = tmo_cnt;
    pulse_nxt   = pulse_cnt;
    locked_nxt  = locked;
    failed_nxt  = failed;
    retry_nxt   = retry_count;
    status_nxt  = last_status;
    tmo_err_nxt = read_timeout_err;

    if ((next_state == WAIT_POLL) && (state != WAIT_POLL))
      poll_nxt = POLL_W'(POLL_INTERVAL - 1);
    else if ((state == WAIT_POLL) && !poll_done_c)
      poll_nxt = poll_cnt - POLL_W'(1);

    case (state)
      READ: begin
        tmo_nxt = '0;
        if (accept_c && rdv_c) status_nxt = avm.avm_readdata;
      end
      WAIT_DATA: begin
        tmo_nxt = tmo_cnt + TMO_W'(1);
        if (rdv_c) status_nxt = avm.avm_readdata;
        else if (tmo_done_c) tmo_err_nxt = 1'b1;
      end
      DECIDE: begin
        if (enable) begin
          locked_nxt = ok_c;
          if (ok_c) retry_nxt = '0;
          if (fail_c && can_retry_c) begin
            retry_nxt = (retry_count == 4'd15) ? 4'd15 : retry_count + 4'd1;
            pulse_nxt = PULSE_W'(RESET_CYCLES - 1);
          end else if (fail_c) begin
            failed_nxt = 1'b1;
          end
        end
      end
      RESET_PULSE: if (!pulse_done_c) pulse_nxt = pulse_cnt - PULSE_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt          <= '0;
      tmo_cnt           <= '0;
      pulse_cnt         <= '0;
      read_q            <= 1'b0;
      pll_reset_request <= 1'b0;
      locked            <= 1'b0;
      failed            <= 1'b0;
      retry_count       <= '0;
      last_status       <= '0;
      read_timeout_err  <= 1'b0;
    end else begin
      poll_cnt          <= poll_nxt;
      tmo_cnt           <= tmo_nxt;
      pulse_cnt         <= pulse_nxt;
      read_q            <= read_nxt;
      pll_reset_request <= rreq_nxt;
      locked            <= locked_nxt;
      failed            <= failed_nxt;
      retry_count       <= retry_nxt;
      last_status       <= status_nxt;
      read_timeout_err  <= tmo_err_nxt;
    end
  end

  assign avm.avm_address = 4'd0;
  assign avm.avm_read    = read_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: a procedural timeline model predicts every
// output each cycle while the bench plays the CSR slave with random timing.
module tb_pll_lock_supervisor;
  localparam int unsigned POLL  = 64;
  localparam int unsigned RCYC  = 4;
  localparam int unsigned MAXR  = 3;
  localparam int unsigned TMO   = 16;
  localparam int unsigned SBIT  = 24;
  localparam int unsigned FBIT  = 26;
  localparam int NO_RESP = 99;

  logic clk = 1'b0;
  logic reset, enable;
  logic slv_wait, slv_rdv;
  logic [31:0] slv_data;
  logic pll_reset_request, locked, failed, read_timeout_err;
  logic [3:0] retry_count;
  logic [31:0] last_status;

  logic exp_read, exp_rreq, exp_locked, exp_failed, exp_terr;
  logic [3:0] exp_retry;
  logic [31:0] exp_status;

  int vectors = 0;
  int miscompares = 0;
  bit check_on = 0;
  int cyc = 0;
  int rd_cycles = 0;
  int rreq_cycles = 0;
  int rd_first = -1;
  int en_edge = 0;

  pll_lock_supervisor_if avm();
  assign avm.avm_waitrequest   = slv_wait;
  assign avm.avm_readdatavalid = slv_rdv;
  assign avm.avm_readdata      = slv_data;

  pll_lock_supervisor #(
    .POLL_INTERVAL(POLL), .RESET_CYCLES(RCYC), .MAX_RETRIES(MAXR),
    .READ_TIMEOUT(TMO), .SUCCESS_BIT(SBIT), .FAILURE_BIT(FBIT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .avm(avm),
    .pll_reset_request(pll_reset_request), .locked(locked), .failed(failed),
    .retry_count(retry_count), .last_status(last_status),
    .read_timeout_err(read_timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clk) begin
    if (check_on) begin
      check("avm_address", 32'(avm.avm_address), 32'd0);
      check("avm_read", 32'(avm.avm_read), 32'(exp_read));
      check("pll_reset_request", 32'(pll_reset_request), 32'(exp_rreq));
      check("locked", 32'(locked), 32'(exp_locked));
      check("failed", 32'(failed), 32'(exp_failed));
      check("retry_count", 32'(retry_count), 32'(exp_retry));
      check("last_status", last_status, exp_status);
      check("read_timeout_err", 32'(read_timeout_err), 32'(exp_terr));
    end
    if (avm.avm_read) begin
      rd_cycles++;
      if (rd_first < 0) rd_first = cyc;
    end
    if (pll_reset_request) rreq_cycles++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    exp_read = 0; exp_rreq = 0; exp_locked = 0; exp_failed = 0;
    exp_terr = 0; exp_retry = '0; exp_status = '0;
  endtask

  // Asynchronous reset raised mid-cycle; leaves the DUT just entered the poll wait.
  task automatic do_reset();
    #2;
    reset = 1;
    #1;
    check("rst_rreq_now", 32'(pll_reset_request), 32'd0);
    check("rst_read_now", 32'(avm.avm_read), 32'd0);
    check("rst_locked_now", 32'(locked), 32'd0);
    check("rst_failed_now", 32'(failed), 32'd0);
    check("rst_retry_now", 32'(retry_count), 32'd0);
    check("rst_status_now", last_status, 32'd0);
    check("rst_terr_now", 32'(read_timeout_err), 32'd0);
    clear_exp();
    slv_wait = 0; slv_rdv = 0;
    step(); step();
    reset = 0;
    enable = 1;
    step();
  endtask

  // Poll interval from the edge that entered the wait, with optional enable drop.
  task automatic poll_wait(input bit drop_ok);
    int k = 0;
    int drop_at = -1;
    if (drop_ok && $urandom_range(0, 3) == 0) drop_at = int'($urandom_range(0, POLL - 1));
    while (k < int'(POLL)) begin
      slv_wait = 1'($urandom_range(0, 1));
      slv_rdv  = ($urandom_range(0, 7) == 0);
      slv_data = $urandom();
      if (k == drop_at) begin
        drop_at = -1;
        enable = 0;
        step();
        repeat ($urandom_range(0, 3)) step();
        enable = 1;
        step();
        k = 0;
      end else begin
        step();
        k++;
      end
    end
    slv_wait = 0; slv_rdv = 0;
    exp_read = 1;
  endtask

  // One read: nw stall cycles, response lat cycles after acceptance (0 = same cycle).
  task automatic do_read(input int nw, input int lat, input logic [31:0] data, output bit got);
    for (int i = 0; i <= nw; i++) begin
      slv_wait = (i < nw);
      slv_rdv  = (i == nw) && (lat == 0);
      slv_data = slv_rdv ? data : $urandom();
      step();
      if (i == nw) begin
        exp_read = 0;
        if (lat == 0) exp_status = data;
      end
    end
    slv_wait = 0; slv_rdv = 0;
    got = (lat == 0);
    for (int j = 1; j <= int'(TMO) && !got; j++) begin
      slv_rdv  = (j == lat);
      slv_data = slv_rdv ? data : $urandom();
      step();
      if (j == lat) begin
        exp_status = data;
        got = 1;
      end
    end
    slv_rdv = 0;
    if (!got) exp_terr = 1;
  endtask

  task automatic do_decide(input logic [31:0] data, input int rst_at);
    step();
    if (data[FBIT]) begin
      exp_locked = 0;
      if (int'(exp_retry) < int'(MAXR)) begin
        exp_retry = (exp_retry == 4'd15) ? 4'd15 : exp_retry + 4'd1;
        exp_rreq = 1;
        for (int p = 1; p <= int'(RCYC); p++) begin
          if (p == rst_at) begin
            do_reset();
            return;
          end
          step();
        end
        exp_rreq = 0;
      end else begin
        exp_failed = 1;
      end
    end else if (data[SBIT]) begin
      exp_locked = 1;
      exp_retry = '0;
    end else begin
      exp_locked = 0;
    end
  endtask

  task automatic txn(input int nw, input int lat, input logic [31:0] data, input int rst_at, input bit drop_ok);
    bit got;
    poll_wait(drop_ok);
    do_read(nw, lat, data, got);
    if (got) do_decide(data, rst_at);
  endtask

  task automatic hold_failed();
    repeat (2 * POLL) begin
      slv_wait = 1'($urandom_range(0, 1));
      step();
    end
    slv_wait = 0;
  endtask

  initial begin
    logic [31:0] d;
    int nw, lat, ra;
    reset = 1; enable = 0;
    slv_wait = 0; slv_rdv = 0; slv_data = '0;
    clear_exp();
    repeat (3) step();
    reset = 0;
    check_on = 1;
    step();
    check("idle_read", 32'(avm.avm_read), 32'd0);
    check("idle_locked", 32'(locked), 32'd0);

    // Success path
    rd_cycles = 0; rreq_cycles = 0; rd_first = -1;
    enable = 1;
    en_edge = cyc + 1;
    step();
    txn(2, 1, 32'h0340009C, -1, 0);
    check("first_read_delay", 32'(rd_first - en_edge), 32'd64);
    check("read_held", 32'(rd_cycles), 32'd3);
    check("d1_locked", 32'(locked), 32'd1);
    check("d1_status", last_status, 32'h0340009C);
    check("d1_no_rreq", 32'(rreq_cycles), 32'd0);

    // Failure with recovery
    rreq_cycles = 0;
    txn(0, 3, 32'h04400088, -1, 0);
    check("d2_pulse_len", 32'(rreq_cycles), 32'd4);
    check("d2_retry", 32'(retry_count), 32'd1);
    txn(1, 2, 32'h0340009C, -1, 0);
    check("d2_locked", 32'(locked), 32'd1);
    check("d2_retry_clr", 32'(retry_count), 32'd0);

    // Permanent failure
    rreq_cycles = 0;
    repeat (4) txn(0, 1, 32'h04400088, -1, 0);
    check("d3_pulses", 32'(rreq_cycles), 32'd12);
    check("d3_retry", 32'(retry_count), 32'd3);
    check("d3_failed", 32'(failed), 32'd1);
    rd_cycles = 0; rreq_cycles = 0;
    hold_failed();
    check("d3_no_read", 32'(rd_cycles), 32'd0);
    check("d3_no_rreq", 32'(rreq_cycles), 32'd0);
    do_reset();

    // Pending after lock
    txn(0, 0, 32'h0340009C, -1, 0);
    rreq_cycles = 0;
    txn(1, 4, 32'h00400074, -1, 0);
    check("d4_locked", 32'(locked), 32'd0);
    check("d4_status", last_status, 32'h00400074);
    check("d4_no_rreq", 32'(rreq_cycles), 32'd0);

    // Read timeout then success
    txn(1, NO_RESP, 32'h0, -1, 0);
    check("d5_terr", 32'(read_timeout_err), 32'd1);
    txn(0, 2, 32'h0340009C, -1, 0);
    check("d5_locked", 32'(locked), 32'd1);

    // Reset mid-pulse, then both status bits set
    txn(0, 1, 32'h04400088, 2, 0);
    rreq_cycles = 0;
    txn(0, 2, 32'h05000000, -1, 0);
    check("d6_both_retry", 32'(retry_count), 32'd1);
    check("d6_both_pulse", 32'(rreq_cycles), 32'd4);
    check("d6_both_locked", 32'(locked), 32'd0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: d = 32'h0340009C;
        1: d = 32'h04400088;
        2: d = 32'h00400074;
        3: d = 32'h05000000;
        default: d = $urandom();
      endcase
      nw  = int'($urandom_range(0, 3));
      lat = ($urandom_range(0, 7) == 0) ? NO_RESP : int'($urandom_range(0, 16));
      ra  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, RCYC)) : -1;
      txn(nw, lat, d, ra, exp_retry == 4'd0);
      if (exp_failed) begin
        hold_failed();
        do_reset();
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
